// File: rtl/err_rate_mon_if.sv
// err_rate_mon_if: sample bus into the error-rate monitor and its registered status back to the control unit.
interface err_rate_mon_if #(parameter int W = 8);
    logic         vld;
    logic [2:0]   en;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         chk_err;
    logic [3:0]   err_rate;
    logic         win_done;
    logic [1:0]   bad_idx;
    modport master (output vld, en, d0, d1, d2, chk_err, input err_rate, win_done, bad_idx);
    modport slave (input vld, en, d0, d1, d2, chk_err, output err_rate, win_done, bad_idx);
endinterface

// File: rtl/err_rate_mon.sv
// err_rate_mon: counts erroneous TMR samples per window of WIN valid samples and publishes a saturated 4-bit rate.
// Define ERR_RATE_MON_DECAY_EN to publish the rounded-up average of the new count and the previous rate.
module err_rate_mon #(
    parameter int W   = 8,
    parameter int WIN = 16
) (
    input logic clk,
    input logic rst,
    err_rate_mon_if.slave bus
);
    localparam int WW = $clog2(WIN);
    logic [W-1:0]  d0, d1, d2;
    logic [WW-1:0] widx_q, widx_d;
    logic [3:0]    ecnt_q, ecnt_d, rate_q, rate_d, c;
    logic          done_q, done_d;
    logic [1:0]    bad_q, bad_d;
    logic          tmr, mis, e, last;
`ifdef ERR_RATE_MON_DECAY_EN
    logic [4:0]    sum;
`endif
    assign d0 = bus.d0;
    assign d1 = bus.d1;
    assign d2 = bus.d2;
    always_comb begin
        tmr    = bus.en == 3'b111;
        mis    = !(d0 == d1 && d1 == d2);
        e      = bus.chk_err | (tmr & mis);
        // the closing sample is folded into the published count
        c      = (ecnt_q == 4'hF) ? ecnt_q : ecnt_q + {3'b000, e};
        last   = widx_q == WW'(WIN - 1);
        widx_d = !bus.vld ? widx_q : last ? '0 : widx_q + WW'(1);
        ecnt_d = !bus.vld ? ecnt_q : last ? '0 : c;
        done_d = bus.vld & last;
`ifdef ERR_RATE_MON_DECAY_EN
        sum    = {1'b0, rate_q} + {1'b0, c} + 5'd1;
        rate_d = done_d ? 4'(sum >> 1) : rate_q;
`else
        rate_d = done_d ? c : rate_q;
`endif
        bad_d  = !(bus.vld & tmr & mis) ? bad_q :
                 (d1 == d2) ? 2'b01 :
                 (d0 == d2) ? 2'b10 :
                 (d0 == d1) ? 2'b11 : 2'b00;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_q <= '0;
            ecnt_q <= '0;
            rate_q <= '0;
            done_q <= 1'b0;
            bad_q  <= 2'b00;
        end else begin
            widx_q <= widx_d;
            ecnt_q <= ecnt_d;
            rate_q <= rate_d;
            done_q <= done_d;
            bad_q  <= bad_d;
        end
    end
    assign bus.err_rate = rate_q;
    assign bus.win_done = done_q;
    assign bus.bad_idx  = bad_q;
endmodule

// File: doc/err_rate_mon.md
# err_rate_mon

Error-rate monitor feeding the TMR control unit. Samples the three replica outputs and an external check flag on every valid cycle. Counts erroneous samples over a fixed window of valid samples. Publishes a saturated 4-bit error rate at each window close, which the control unit compares against its escalation threshold (>5) to switch between simplex and full TMR.

## Interface
Parameters:
- W, 8, width of each replica result.
- WIN, 16, valid samples per window; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- vld  in  1  sample strobe; d0/d1/d2/chk_err/en are sampled only when high.
- en  in  3  replica enables currently driven by the control unit.
- d0, d1, d2  in  W  replica results.
- chk_err  in  1  external check failure (parity/ECC) on the replica-0 result.
- err_rate  out  4  error count of the last closed window (processed per Configuration).
- win_done  out  1  one-cycle pulse marking an err_rate update.
- bad_idx  out  2  last outvoted replica: 00 none or no majority, 01 d0, 10 d1, 11 d2.

## Operation
- Per-sample error, evaluated only when vld=1: e = chk_err | (tmr & mis).
  - tmr = (en == 3'b111). Any other en value disables replica comparison.
  - mis = !(d0 == d1 && d1 == d2).
- Window index widx has width clog2(WIN). It advances by 1 on each vld cycle. No advance when vld=0.
- Error counter ecnt is 4 bits. It increments on vld & e and saturates at 15 (holds at 15, no wrap).
- Window close occurs on a vld cycle with widx == WIN-1:
  - closing count c = sat15(ecnt + e); the closing sample is included.
  - err_rate updates from c.
  - widx and ecnt clear to 0.
  - win_done = 1 for the following cycle only.
- bad_idx updates on a vld cycle where tmr & mis:
  - d1 == d2 → 01.
  - d0 == d2 → 10.
  - d0 == d1 → 11.
  - all three differ → 00.
  - Otherwise bad_idx holds. chk_err alone never changes bad_idx.
- Changes to en mid-window do not restart the window; each sample uses the en value present when it is sampled.
- Asserting rst mid-window discards the partial window. There is no carry-over.

## Timing
- Reset values: err_rate=0, win_done=0, bad_idx=00, widx=0, ecnt=0.
- All outputs are registered. No combinational path from any input to any output.
- err_rate and win_done change on the clock edge that samples the closing vld. err_rate is visible in the cycle after the closing sample, together with win_done=1.
- err_rate holds between window closes.
- Minimum close spacing is WIN cycles. win_done is never high on two consecutive cycles because WIN ≥ 2.
- bad_idx reflects a mismatch one cycle after the sampling edge.
- The control unit consumes err_rate combinationally. Enable changes therefore reach this block's en input no earlier than the cycle after err_rate updates.

## Configuration
- ERR_RATE_MON_DECAY_EN defined:
  - at close, err_rate <= (err_rate + c + 1) >> 1, using a 5-bit intermediate.
  - This is a rounded-up average with the previous window, which damps single-window bursts.
- ERR_RATE_MON_DECAY_EN undefined: at close, err_rate <= c (raw count).
- Reset value and all other behaviour are identical in both builds.

## Test plan
- Reset: assert rst mid-operation with err_rate=7. Required: all outputs read 0 on the same cycle, with no clock needed; they stay 0 until a window completes.
- TMR window: en=111, WIN=16, 16 consecutive vld samples, 6 of them with d0=8'hA5 and d1=d2=8'h5A. Required: err_rate=6 and win_done high for one cycle after the 16th sample; bad_idx=01.
- Simplex gating: en=001, 16 samples with all replicas disagreeing and chk_err=1 on 3 samples. Required: err_rate=3, bad_idx unchanged from 00.
- Saturation and gaps: en=111, 16 mismatching samples with vld low every other cycle. Required: err_rate=15 after the 16th vld (31 cycles); win_done pulses exactly once.
- Decay: two consecutive windows with counts 10 then 0. Required with ERR_RATE_MON_DECAY_EN: err_rate=5, then 3. Required without the macro: err_rate=10, then 0.
- Reset mid-window: 5 errors, pulse rst, then 16 clean samples. Required: err_rate=0 at close; the pre-reset errors are not counted.
